// File: rtl/spram_arb.sv
// spram_arb: two-requester arbiter for the 32 KB single-port byte SPRAM.
// The CPU port has priority and is stalled through cpu_rdy. The secondary
// master (DMA/video) takes a grant through dma_req/dma_gnt and preempts the
// CPU after MAX_WAIT refused cycles. Read data comes back one cycle after
// the grant and is steered to the requester that issued the read.
// Optional feature: define SPRAM_CLEAR_EN to compile in a post-reset
// zero-fill of all 32768 bytes. While it runs, clr_busy is high and both
// requesters are held off.
//
// Handshake: a request is accepted in any cycle where its accept output
// (cpu_rdy or dma_gnt) is high. The requester holds req and its qualifiers
// stable until it sees that accept. The accept is combinational on the
// current-cycle request, so an uncontended access completes with no wait.
module spram_arb #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [14:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [14:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [7:0]  dma_rdata,
    output logic        ram_sel,
    output logic        ram_we,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic        clr_busy
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    // Owner of the read issued last cycle; write and idle cycles record NONE.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

    logic [3:0]  r_starve_cnt;
    logic [1:0]  r_owner;
    logic        w_clearing;
    logic        w_force;
    logic        w_cpu_win;
    logic        w_dma_win;

`ifdef SPRAM_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]  r_state;
    logic [14:0] r_clr_cnt;

    // Clear sequencer: one zero write per cycle, then hand over to RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= 15'd0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 15'd1;
            if (r_clr_cnt == 15'h7FFF) begin
                r_state <= ST_RUN;
            end
        end
    end

    assign w_clearing = (r_state == ST_CLEAR);
`else
    assign w_clearing = 1'b0;
`endif

    assign w_force = dma_req && (r_starve_cnt == LP_MAX_WAIT);

    // Arbitration and RAM drive; everything is held at its reset value while
    // reset_n is low so an abort is visible immediately.
    always_comb begin
        w_cpu_win = 1'b0;
        w_dma_win = 1'b0;
        ram_sel   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = 15'd0;
        ram_din   = 8'd0;
        if (reset_n) begin
            if (w_clearing) begin
                ram_sel = 1'b1;
                ram_we  = 1'b1;
`ifdef SPRAM_CLEAR_EN
                ram_addr = r_clr_cnt;
`endif
            end else if (cpu_req && !w_force) begin
                w_cpu_win = 1'b1;
                ram_sel   = 1'b1;
                ram_we    = cpu_we;
                ram_addr  = cpu_addr;
                ram_din   = cpu_wdata;
            end else if (dma_req) begin
                w_dma_win = 1'b1;
                ram_sel   = 1'b1;
                ram_we    = dma_we;
                ram_addr  = dma_addr;
                ram_din   = dma_wdata;
            end
        end
    end

    assign cpu_rdy = w_cpu_win;
    assign dma_gnt = w_dma_win;

    // Starvation counter: counts refused DMA cycles, saturating at MAX_WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= 4'd0;
        end else if (!dma_req || w_dma_win) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != LP_MAX_WAIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Read steering: remember who issued this cycle's read for next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= OWN_NONE;
        end else if (w_cpu_win && !cpu_we) begin
            r_owner <= OWN_CPU;
        end else if (w_dma_win && !dma_we) begin
            r_owner <= OWN_DMA;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    assign dma_rvalid = (r_owner == OWN_DMA);
    assign cpu_rdata  = ram_dout;
    assign dma_rdata  = ram_dout;
    assign clr_busy   = w_clearing;

endmodule

// File: tb/tb_spram_arb.sv
// Directed testbench for spram_arb with a behavioural 32 KB RAM attached.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_spram_arb;

    logic        clk;
    logic        reset_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rdy;
    logic [7:0]  cpu_rdata;
    logic        dma_req;
    logic        dma_we;
    logic [14:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [7:0]  dma_rdata;
    logic        ram_sel;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        clr_busy;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SPRAM_CLEAR_EN
    localparam logic EXP_CLR_RESET = 1'b1;
`else
    localparam logic EXP_CLR_RESET = 1'b0;
`endif

    spram_arb #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdy    (cpu_rdy),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .ram_sel    (ram_sel),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .clr_busy   (clr_busy)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: read data registered one cycle later.
    logic [7:0] mem [0:32767];
    always @(posedge clk) begin
        if (ram_sel) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cpu(input logic req, input logic we, input logic [14:0] addr, input logic [7:0] data);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    endtask

    task automatic drive_dma(input logic req, input logic we, input logic [14:0] addr, input logic [7:0] data);
        dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = data;
    endtask

    // Move to the next falling edge; caller drives inputs then waits #1.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Watch the clear sequence; stops when clr_busy falls, at abort_at, or
    // at a cycle budget. Counts cycles whose RAM drive is not the expected
    // zero write to the current index, or whose grants are not low.
    task automatic watch_clear(input int abort_at, output int cycles, output int bad);
        int n;
        n   = 0;
        bad = 0;
        while (clr_busy && n < 40000 && !(abort_at >= 0 && n == abort_at)) begin
            if (!(ram_sel && ram_we && ram_addr == n[14:0] && ram_din == 8'h00 &&
                  !cpu_rdy && !dma_gnt)) bad++;
            n++;
            next_cycle(); #1;
        end
        cycles = n;
    endtask

    initial begin
        int cyc;
        int bad;

        // Reset with both requests pending: everything must stay at reset values.
        reset_n = 1'b0;
        drive_cpu(1'b1, 1'b1, 15'h0555, 8'hFF);
        drive_dma(1'b1, 1'b1, 15'h0AAA, 8'hFF);
        next_cycle(); #1;
        check("rst_cpu_rdy",    cpu_rdy,    0);
        check("rst_dma_gnt",    dma_gnt,    0);
        check("rst_dma_rvalid", dma_rvalid, 0);
        check("rst_ram_sel",    ram_sel,    0);
        check("rst_ram_we",     ram_we,     0);
        check("rst_ram_addr",   ram_addr,   0);
        check("rst_ram_din",    ram_din,    0);
        check("rst_clr_busy",   clr_busy,   EXP_CLR_RESET);

`ifdef SPRAM_CLEAR_EN
        // Clear with requests held (grants must stay low), aborted at 0x1000.
        next_cycle();
        reset_n = 1'b1;
        #1;
        watch_clear(32'h1000, cyc, bad);
        check("clr_abort_at",  cyc, 32'h1000);
        check("clr_first_bad", bad, 0);
        reset_n = 1'b0;
        #1;
        check("clr_abort_sel",  ram_sel,  0);
        check("clr_abort_busy", clr_busy, 1);
        next_cycle();
        reset_n = 1'b1;
        #1;
        check("clr_restart_addr", ram_addr, 0);
        watch_clear(-1, cyc, bad);
        check("clr_cycles", cyc, 32768);
        check("clr_bad",    bad, 0);
        check("clr_busy_done", clr_busy, 0);
        // Starvation accrued during the clear: let it drain with an idle cycle.
        drive_cpu(1'b0, 1'b0, 15'h0, 8'h0);
        drive_dma(1'b0, 1'b0, 15'h0, 8'h0);
        next_cycle(); #1;
        check("clr_mem_sample", mem[15'h1234], 8'h00);
`else
        next_cycle();
        reset_n = 1'b1;
        drive_cpu(1'b0, 1'b0, 15'h0, 8'h0);
        drive_dma(1'b0, 1'b0, 15'h0, 8'h0);
        #1;
        check("run_clr_busy", clr_busy, 0);
        check("run_idle_sel", ram_sel,  0);
`endif

        // CPU only: write 0xA5 to 0x1234, then read it back.
        next_cycle();
        drive_cpu(1'b1, 1'b1, 15'h1234, 8'hA5);
        #1;
        check("cpuw_rdy",  cpu_rdy,  1);
        check("cpuw_gnt",  dma_gnt,  0);
        check("cpuw_sel",  ram_sel,  1);
        check("cpuw_we",   ram_we,   1);
        check("cpuw_addr", ram_addr, 15'h1234);
        check("cpuw_din",  ram_din,  8'hA5);
        next_cycle();
        drive_cpu(1'b1, 1'b0, 15'h1234, 8'h00);
        #1;
        check("cpur_rdy", cpu_rdy, 1);
        check("cpur_we",  ram_we,  0);
        next_cycle();
        drive_cpu(1'b0, 1'b0, 15'h0, 8'h0);
        #1;
        check("cpur_data",   cpu_rdata,  8'hA5);
        check("cpur_rvalid", dma_rvalid, 0);
        check("idle_sel",    ram_sel,    0);

        // DMA only: fill 0x4000..0x4003 with 0x11..0x44, then read them back.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive_dma(1'b1, 1'b1, 15'h4000 + 15'(i), 8'(8'h11 * (i + 1)));
            #1;
            check("dmaw_gnt", dma_gnt, 1);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive_dma(1'b1, 1'b0, 15'h4000 + 15'(i), 8'h00);
            #1;
            check("dmar_gnt", dma_gnt, 1);
            if (i == 0) begin
                check("dmar_rvalid_wr", dma_rvalid, 0);
            end else begin
                check("dmar_rvalid", dma_rvalid, 1);
                check("dmar_data",   dma_rdata,  8'h11 * i);
            end
        end
        next_cycle();
        drive_dma(1'b0, 1'b0, 15'h0, 8'h0);
        #1;
        check("dmar_rvalid_last", dma_rvalid, 1);
        check("dmar_data_last",   dma_rdata,  8'h44);
        next_cycle(); #1;
        check("dmar_rvalid_off", dma_rvalid, 0);

        // Contention: CPU reads 0x1234, DMA reads 0x4001; grants go CPU x4, DMA x1.
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            drive_cpu(1'b1, 1'b0, 15'h1234, 8'h00);
            drive_dma(1'b1, 1'b0, 15'h4001, 8'h00);
            #1;
            check("cont_cpu_rdy", cpu_rdy, (k % 5) != 4);
            check("cont_dma_gnt", dma_gnt, (k % 5) == 4);
            if (k % 5 == 0 && k > 0) begin
                check("cont_rvalid", dma_rvalid, 1);
                check("cont_rdata",  dma_rdata,  8'h22);
            end else if (k > 0) begin
                check("cont_rvalid_cpu", dma_rvalid, 0);
                check("cont_cpu_rdata",  cpu_rdata,  8'hA5);
            end
        end

        // Simultaneous requests with starve count cleared: CPU first, DMA next.
        next_cycle();
        drive_cpu(1'b1, 1'b1, 15'h0100, 8'h5A);
        drive_dma(1'b1, 1'b1, 15'h0200, 8'h3C);
        #1;
        check("sim_cpu_rdy", cpu_rdy, 1);
        check("sim_dma_gnt", dma_gnt, 0);
        next_cycle();
        drive_cpu(1'b0, 1'b0, 15'h0, 8'h0);
        #1;
        check("sim2_dma_gnt",  dma_gnt,  1);
        check("sim2_ram_addr", ram_addr, 15'h0200);
        check("sim2_ram_din",  ram_din,  8'h3C);

        // Reset in the middle of a DMA read: outputs drop at once, steering clears.
        next_cycle();
        drive_dma(1'b1, 1'b0, 15'h4002, 8'h00);
        #1;
        check("mid_dma_gnt", dma_gnt, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_gnt", dma_gnt, 0);
        check("mid_rst_sel", ram_sel, 0);
        next_cycle();
        drive_dma(1'b0, 1'b0, 15'h0, 8'h0);
        #1;
        check("mid_rst_rvalid", dma_rvalid, 0);
        check("mid_rst_busy",   clr_busy,   EXP_CLR_RESET);
        reset_n = 1'b1;
        next_cycle(); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spram_arb.md
# spram_arb

Two-requester arbiter and post-reset clear sequencer for the 32 KB single-port SPRAM byte RAM. Sits between the 6502 bus (priority port with ready/stall) and a secondary bus master such as a video fetcher or DMA engine (req/gnt port). It drives the RAM's select, write-enable, address and data inputs, and steers the one-cycle-late read data back to whichever requester issued the read.

## Interface
Parameters:
- MAX_WAIT, 4: cycles `dma_req` may be refused before it preempts the CPU; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held, with its qualifiers, until `cpu_rdy` is sampled high.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  15  byte address.
- cpu_wdata  in  8  write data.
- cpu_rdy  out  1  CPU access accepted this cycle.
- cpu_rdata  out  8  read data; valid the cycle after an accepted read.
- dma_req  in  1  secondary request; held until `dma_gnt` is high.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  15  byte address.
- dma_wdata  in  8  write data.
- dma_gnt  out  1  secondary access accepted this cycle.
- dma_rvalid  out  1  pulses the cycle after a granted secondary read.
- dma_rdata  out  8  read data; qualified by `dma_rvalid`.
- ram_sel  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_addr  out  15  RAM byte address.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data; valid one cycle after a selected read.
- clr_busy  out  1  clear sequence in progress.

## Operation
- States: CLEAR (present only with the macro) and RUN.
- Reset value:
  - With the macro, reset enters CLEAR with `clr_cnt` = 0.
  - Without the macro, reset enters RUN.
- CLEAR, each cycle:
  - Drives `ram_sel`=1, `ram_we`=1, `ram_addr`=`clr_cnt`, `ram_din`=0x00.
  - Holds `cpu_rdy` and `dma_gnt` low.
  - Increments `clr_cnt` (15-bit). At `clr_cnt`=0x7FFF the write is issued and the state moves to RUN next cycle.
- RUN arbitration, combinational on the current-cycle requests:
  - `force` = `dma_req` & (`starve_cnt` == MAX_WAIT).
  - CPU wins if `cpu_req` & !`force`.
  - Otherwise DMA wins if `dma_req`.
  - Otherwise the cycle is idle: `ram_sel`=0, `ram_we`=0.
- Winner drives the RAM: its `_we`, `_addr` and `_wdata` pass to `ram_we`, `ram_addr` and `ram_din`, with `ram_sel`=1. `cpu_rdy` or `dma_gnt` is high for the winner only.
- Starvation counter (`starve_cnt`, 4 bits):
  - Cleared on `dma_gnt` or when `dma_req`=0.
  - Incremented when `dma_req`=1 and the grant is refused.
  - Saturates at MAX_WAIT.
- Read steering:
  - Registered `owner_q` ∈ {NONE, CPU, DMA} records the winner of each read cycle. Write and idle cycles record NONE.
  - `dma_rvalid` = (`owner_q` == DMA).
  - `dma_rdata` and `cpu_rdata` = `ram_dout` (passthrough).
- Reset asserted mid-operation aborts everything:
  - All outputs are forced to their reset values.
  - With the macro, the clear restarts at address 0.

## Timing
- Reset values: `cpu_rdy`=0, `dma_gnt`=0, `dma_rvalid`=0, `ram_sel`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `owner_q`=NONE, `starve_cnt`=0.
  - `clr_busy`=1 with the macro, 0 without it.
- Grant is zero-latency: a request with no contention is accepted in the cycle it is presented.
- Read data arrives one cycle after the grant cycle.
- Back-to-back grants to the same requester are allowed every cycle.
- CPU worst-case stall is 1 cycle per MAX_WAIT+1 cycles while DMA saturates.
- DMA worst-case wait is MAX_WAIT cycles under continuous CPU traffic.
- CLEAR takes exactly 32768 cycles. First RUN grant is possible on cycle 32768 after reset deassertion.
- A forced DMA grant clears `starve_cnt`, so the CPU wins the following cycle if it is requesting.

## Configuration
- `SPRAM_CLEAR_EN` defined:
  - CLEAR state, `clr_cnt` and the zero-fill are compiled in.
  - `clr_busy` behaves as above.
- `SPRAM_CLEAR_EN` undefined:
  - No CLEAR state; RUN is entered from reset.
  - `clr_busy` is tied 0.
  - RAM contents are left unmodified at reset.

## Test plan
- Clear (macro on): release reset and watch 32768 cycles. Every address 0x0000..0x7FFF is written with 0x00 exactly once. `clr_busy` falls on cycle 32768, and the grants stay low throughout.
- CPU only: write 0xA5 to 0x1234, then read 0x1234. `cpu_rdy` is high on both request cycles, and `cpu_rdata`=0xA5 on the cycle after the read.
- DMA only: read four consecutive addresses 0x4000..0x4003 preloaded with 0x11..0x44. Four consecutive `dma_gnt` cycles occur, then `dma_rvalid` pulses carrying 0x11, 0x22, 0x33, 0x44.
- Contention, MAX_WAIT=4: hold `cpu_req` and `dma_req` continuously.
  - Grant pattern repeats CPU×4, DMA×1.
  - `cpu_rdy` is low on every fifth cycle.
- Simultaneous single requests with `starve_cnt`=0: the CPU is granted. DMA is granted the next cycle once the CPU releases.
- Reset mid-clear (macro on): assert `reset_n` low at `clr_cnt`=0x1000 and release. The clear restarts at 0x0000 and completes 32768 cycles later.
